// File: rtl/logic_unit_arbiter_if.sv
// Request/grant/result bundle between the clients and the shared logic unit.
// The master modport is the client side; the slave modport is the arbiter.
interface logic_unit_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
) ();
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a;
    logic [NREQ*WIDTH-1:0] op_b;
    logic [NREQ*2-1:0]     op_sel;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      result;
    logic                  busy;

    modport master (
        output req, op_a, op_b, op_sel,
        input  gnt, done, result, busy
    );

    modport slave (
        input  req, op_a, op_b, op_sel,
        output gnt, done, result, busy
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin shared bitwise logic unit (AND/OR/XOR/NOT A) for NREQ requesters.
// Each operation takes three cycles: grant/latch, execute, respond with done pulse.
// Optional feature: define LU_ARB_STATS_EN to add a saturating op_count output.
module logic_unit_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    logic_unit_arbiter_if.slave bus
`ifdef LU_ARB_STATS_EN
    ,
    output logic [15:0]        op_count
`endif
);
    localparam int unsigned PTR_W = $clog2(NREQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e             state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         sel_q, sel_d;

    logic               req_any;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;
    int unsigned        scan_idx;
    logic [WIDTH-1:0]   a_win, b_win;
    logic [1:0]         sel_win;

    function automatic logic [WIDTH-1:0] lu_eval(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [1:0]       sel);
        logic [WIDTH-1:0] r;
        unique case (sel)
            2'b00: r = a & b;
            2'b01: r = a | b;
            2'b10: r = a ^ b;
            2'b11: r = ~a;
        endcase
        return r;
    endfunction

    // Round-robin search: first requester at or after rr_q, wrapping mod NREQ.
    always_comb begin
        req_any  = 1'b0;
        win_idx  = '0;
        cand     = '0;
        scan_idx = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            scan_idx = 32'(rr_q) + i;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            cand = PTR_W'(scan_idx);
            if (!req_any && bus.req[cand]) begin
                req_any = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Operand mux for the current winner.
    always_comb begin
        a_win   = '0;
        b_win   = '0;
        sel_win = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (PTR_W'(i) == win_idx) begin
                a_win   = bus.op_a[i*WIDTH +: WIDTH];
                b_win   = bus.op_b[i*WIDTH +: WIDTH];
                sel_win = bus.op_sel[i*2 +: 2];
            end
        end
    end

    // Next-state and datapath updates; requests are only looked at in StIdle.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        result_d = result_q;
        rr_d     = rr_q;
        win_d    = win_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    win_d          = win_idx;
                    a_d            = a_win;
                    b_d            = b_win;
                    sel_d          = sel_win;
                    state_d        = StExec;
                end
            end
            StExec: begin
                result_d = lu_eval(a_q, b_q, sel_q);
                done_d   = gnt_q;
                state_d  = StResp;
            end
            StResp: begin
                gnt_d   = '0;
                rr_d    = (win_q == LAST_IDX) ? '0 : win_q + PTR_W'(1);
                state_d = StIdle;
            end
            default: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= '0;
            rr_q     <= '0;
            win_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            rr_q     <= rr_d;
            win_q    <= win_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.busy   = (state_q != StIdle);

`ifdef LU_ARB_STATS_EN
    logic [15:0] op_count_q;

    // Completed-operation counter, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_q <= '0;
        end else if (state_q == StResp && op_count_q != 16'hFFFF) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Randomized + directed bench for logic_unit_arbiter (NREQ=4, WIDTH=8).
// A cycle-level reference model predicts outputs; a monitor compares them.
module tb_logic_unit_arbiter;
    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    typedef struct {
        logic [N-1:0] gnt;
        logic         busy;
        logic [N-1:0] done;
        logic [W-1:0] result;
        logic [15:0]  ops;
    } cyc_t;

    typedef struct {
        logic [N-1:0] done;
        logic [W-1:0] result;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic_unit_arbiter_if #(.NREQ(N), .WIDTH(W)) bus ();

`ifdef LU_ARB_STATS_EN
    logic [15:0] op_count;
`endif

    logic_unit_arbiter #(.NREQ(N), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef LU_ARB_STATS_EN
        ,
        .op_count (op_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    cyc_t         cyc_q[$];
    rsp_t         sb_q[$];
    rsp_t         done_log[$];
    logic [N-1:0] gnt_log[$];
    logic [N-1:0] prev_gnt;

    // Reference model state
    int           m_rr, m_cnt, m_win;
    logic [W-1:0] m_a, m_b, m_result;
    logic [1:0]   m_sel;
    logic [15:0]  m_ops;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] sel);
        case (sel)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    task automatic model_reset();
        m_rr = 0; m_cnt = 0; m_win = 0;
        m_a = '0; m_b = '0; m_sel = '0; m_result = '0; m_ops = '0;
    endtask

    // Predict what the next rising edge produces, given the inputs now applied.
    task automatic model_step(input logic [N-1:0] r, input logic [N*W-1:0] a,
                              input logic [N*W-1:0] b, input logic [2*N-1:0] s);
        cyc_t e;
        e.gnt = '0; e.busy = 1'b0; e.done = '0;
        if (m_cnt == 0) begin
            if (r != '0) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_rr + k) % N;
                    if (r[idx] && m_cnt == 0) begin
                        m_win = idx;
                        m_cnt = 2;
                    end
                end
                m_a   = a[m_win*W +: W];
                m_b   = b[m_win*W +: W];
                m_sel = s[m_win*2 +: 2];
                m_rr  = (m_win + 1) % N;
                e.gnt = N'(1) << m_win;
                e.busy = 1'b1;
            end
        end else if (m_cnt == 2) begin
            m_result = ref_op(m_a, m_b, m_sel);
            e.gnt  = N'(1) << m_win;
            e.busy = 1'b1;
            e.done = N'(1) << m_win;
            sb_q.push_back('{done: e.done, result: m_result});
            m_cnt = 1;
        end else begin
            if (m_ops != 16'hFFFF) m_ops = m_ops + 16'd1;
            m_cnt = 0;
        end
        e.result = m_result;
        e.ops    = m_ops;
        cyc_q.push_back(e);
    endtask

    task automatic cycle(input logic [N-1:0] r, input logic [N*W-1:0] a,
                         input logic [N*W-1:0] b, input logic [2*N-1:0] s);
        @(negedge clk);
        bus.req = r; bus.op_a = a; bus.op_b = b; bus.op_sel = s;
        model_step(r, a, b, s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, $urandom, $urandom, N*2'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b1;
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc_q.delete(); sb_q.delete();
        prev_gnt = '0;
        model_reset();
        mon_en = 1'b1;
    endtask

    // Monitor: per-cycle comparison plus scoreboard pop on each done pulse.
    initial begin
        prev_gnt = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && cyc_q.size() > 0) begin
                cyc_t e;
                e = cyc_q.pop_front();
                check("gnt", 32'(bus.gnt), 32'(e.gnt));
                check("busy", 32'(bus.busy), 32'(e.busy));
                check("done", 32'(bus.done), 32'(e.done));
                check("result_hold", 32'(bus.result), 32'(e.result));
                check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
                check("done_implies_gnt", 32'(bus.done & ~bus.gnt), 32'd0);
`ifdef LU_ARB_STATS_EN
                check("op_count", 32'(op_count), 32'(e.ops));
`endif
                if (bus.done != '0) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 32'(bus.done), 32'd0);
                    end else begin
                        rsp_t x;
                        x = sb_q.pop_front();
                        check("sb_done", 32'(bus.done), 32'(x.done));
                        check("sb_result", 32'(bus.result), 32'(x.result));
                    end
                    done_log.push_back('{done: bus.done, result: bus.result});
                end
                if (bus.gnt != '0 && prev_gnt == '0) gnt_log.push_back(bus.gnt);
                prev_gnt = bus.gnt;
            end
        end
    end

    initial begin
        logic [N*W-1:0] a, b;
        logic [2*N-1:0] s;
        logic [N-1:0]   r;

        bus.req = '0; bus.op_a = '0; bus.op_b = '0; bus.op_sel = '0;
        model_reset();
        #2;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // Reset asserted mid-EXEC: outputs clear at once, no done follows.
        a = '0; a[0 +: W] = 8'h12;
        cycle(4'b0001, a, a, 8'h00);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("async_gnt", 32'(bus.gnt), 32'd0);
        check("async_done", 32'(bus.done), 32'd0);
        check("async_result", 32'(bus.result), 32'd0);
        check("async_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
        cyc_q.delete(); sb_q.delete();
        prev_gnt = '0;
        model_reset();
        mon_en = 1'b1;
        idle(4);
        check("abort_no_done", 32'(done_log.size()), 32'd0);

        // Single XOR on requester 0.
        done_log.delete(); gnt_log.delete();
        a = '0; b = '0; s = '0;
        a[0 +: W] = 8'hF0; b[0 +: W] = 8'h3C; s[0 +: 2] = 2'b10;
        cycle(4'b0001, a, b, s);
        idle(3);
        check("xor_count", 32'(done_log.size()), 32'd1);
        if (done_log.size() == 1) begin
            check("xor_result", 32'(done_log[0].result), 32'hCC);
            check("xor_done", 32'(done_log[0].done), 32'h1);
        end

        // All four ops on requester 1.
        done_log.delete();
        a = '0; b = '0;
        a[W +: W] = 8'hA5; b[W +: W] = 8'h0F;
        for (int op = 0; op < 4; op++) begin
            s = '0; s[2 +: 2] = 2'(op);
            cycle(4'b0010, a, b, s);
            idle(2);
        end
        idle(1);
        check("ops_count", 32'(done_log.size()), 32'd4);
        if (done_log.size() == 4) begin
            check("and_result", 32'(done_log[0].result), 32'h05);
            check("or_result", 32'(done_log[1].result), 32'hAF);
            check("xor1_result", 32'(done_log[2].result), 32'hAA);
            check("not_result", 32'(done_log[3].result), 32'h5A);
        end

        // All requesters held: rotating grants.
        do_reset();
        done_log.delete(); gnt_log.delete();
        for (int i = 0; i < 15; i++) cycle(4'b1111, {$urandom, $urandom}, {$urandom, $urandom},
                                           8'($urandom));
        idle(2);
        check("rr_count", 32'(gnt_log.size()), 32'd5);
        if (gnt_log.size() == 5) begin
            check("rr_g0", 32'(gnt_log[0]), 32'b0001);
            check("rr_g1", 32'(gnt_log[1]), 32'b0010);
            check("rr_g2", 32'(gnt_log[2]), 32'b0100);
            check("rr_g3", 32'(gnt_log[3]), 32'b1000);
            check("rr_g4", 32'(gnt_log[4]), 32'b0001);
        end

        // Requester 2 drops req during EXEC; op still completes, pointer moves to 3.
        do_reset();
        done_log.delete(); gnt_log.delete();
        cycle(4'b0100, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom));
        idle(2);
        cycle(4'b1111, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom));
        idle(3);
        check("drop_done_count", 32'(done_log.size()), 32'd2);
        if (done_log.size() == 2) check("drop_done", 32'(done_log[0].done), 32'b0100);
        if (gnt_log.size() == 2) check("drop_next_gnt", 32'(gnt_log[1]), 32'b1000);
        else check("drop_gnt_count", 32'(gnt_log.size()), 32'd2);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            cycle(r, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom));
        end
        idle(4);
        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check("cycle_queue_drained", 32'(cyc_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
